// File: rtl/monty_pkg.sv
// Shared definitions for the serial Montgomery multiplier path: default widths,
// FSM encoding and a test modulus reused by the reduction-stage benches.
package monty_pkg;

   localparam int LOGQ_DEF = 60;
   localparam int DW_DEF   = 20;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   // 2^60 - 2^18 + 1, the modulus used by the reduction benches.
   localparam logic [59:0] TEST_Q = 60'hFFFFFFFFFFC0001;

   function automatic int ndig(input int logq, input int dw);
      return logq / dw;
   endfunction

endpackage

// File: rtl/monty_mul_serial_if.sv
// Operand/product handshake bundle between the operand source, the serial
// multiplier and the downstream reduction stage.
interface monty_mul_serial_if #(
   parameter int LOGQ = monty_pkg::LOGQ_DEF
);
   logic                in_valid;
   logic                in_ready;
   logic [LOGQ-1:0]     a;
   logic [LOGQ-1:0]     b;
   logic                out_valid;
   logic                out_ready;
   logic [2*LOGQ-1:0]   c;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, c
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, c
   );
endinterface

// File: rtl/monty_digit_mul.sv
// LOGQ x DW partial-product multiplier with an optional output register
// (FF_MUL=1); digit shift index and last-digit tag travel alongside the product.
module monty_digit_mul #(
   parameter int LOGQ   = monty_pkg::LOGQ_DEF,
   parameter int DW     = monty_pkg::DW_DEF,
   parameter int SW     = 2,
   parameter bit FF_MUL = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LOGQ-1:0]    a,
   input  logic [DW-1:0]      d,
   input  logic               in_vld,
   input  logic [SW-1:0]      in_sh,
   input  logic               in_last,
   output logic [LOGQ+DW-1:0] pp,
   output logic               pp_vld,
   output logic [SW-1:0]      pp_sh,
   output logic               pp_last
);

   logic [LOGQ+DW-1:0] prod;

   assign prod = {{DW{1'b0}}, a} * {{LOGQ{1'b0}}, d};

   if (FF_MUL) begin : g_ff
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            pp      <= '0;
            pp_vld  <= 1'b0;
            pp_sh   <= '0;
            pp_last <= 1'b0;
         end else begin
            pp      <= prod;
            pp_vld  <= in_vld;
            pp_sh   <= in_sh;
            pp_last <= in_last;
         end
      end
   end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign pp      = prod;
      assign pp_vld  = in_vld;
      assign pp_sh   = in_sh;
      assign pp_last = in_last;
   end

endmodule

// File: rtl/monty_mul_serial.sv
// Digit-serial A*B multiplier feeding Montgomery reduction, one DW-bit digit of
// B per cycle. Define MONTY_MUL_EARLY_DONE_EN to stop once the remaining B is zero.
module monty_mul_serial
   import monty_pkg::*;
#(
   parameter int LOGQ   = LOGQ_DEF,
   parameter int DW     = DW_DEF,
   parameter bit FF_MUL = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   monty_mul_serial_if.slave    bus
);

   localparam int NDIG = ndig(LOGQ, DW);
   localparam int LAT  = NDIG + int'(FF_MUL);
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

   if (LOGQ % DW != 0) begin : g_bad_dw
      $error("LOGQ must be a multiple of DW");
   end

   state_t              state, state_n;
   logic [LOGQ-1:0]     a_r;
   logic [LOGQ-1:0]     b_sh;
   logic [CW-1:0]       cnt;
   logic [2*LOGQ-1:0]   acc;
   logic                iss_done;

   logic                issue;
   logic                last_dig;
   logic [LOGQ+DW-1:0]  pp;
   logic                pp_vld;
   logic [CW-1:0]       pp_sh;
   logic                pp_last;

   assign issue = (state == MUL) && !iss_done;

`ifdef MONTY_MUL_EARLY_DONE_EN
   assign last_dig = (cnt == LAST_CNT) || ((b_sh >> DW) == '0);
`else
   assign last_dig = (cnt == LAST_CNT);
`endif

   monty_digit_mul #(
      .LOGQ   (LOGQ),
      .DW     (DW),
      .SW     (CW),
      .FF_MUL (FF_MUL)
   ) u_digit_mul (
      .clk     (clk),
      .rst     (rst),
      .a       (a_r),
      .d       (b_sh[DW-1:0]),
      .in_vld  (issue),
      .in_sh   (cnt),
      .in_last (last_dig),
      .pp      (pp),
      .pp_vld  (pp_vld),
      .pp_sh   (pp_sh),
      .pp_last (pp_last)
   );

   // NOTE: defaults first so every path assigns state_n and no latch is inferred.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (bus.in_valid)       state_n = MUL;
         MUL:     if (pp_vld && pp_last)  state_n = DONE;
         DONE:    if (bus.out_ready)      state_n = IDLE;
         default:                         state_n = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         a_r      <= '0;
         b_sh     <= '0;
         cnt      <= '0;
         acc      <= '0;
         iss_done <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE && bus.in_valid) begin
            a_r      <= bus.a;
            b_sh     <= bus.b;
            cnt      <= '0;
            acc      <= '0;
            iss_done <= 1'b0;
         end else begin
            if (issue) begin
               b_sh <= b_sh >> DW;
               cnt  <= cnt + 1'b1;
               if (last_dig) iss_done <= 1'b1;
            end
            // Partial products arrive in digit order; pp_sh places each one.
            if (pp_vld) begin
               acc <= acc + ((2*LOGQ)'(pp) << (DW * int'(pp_sh)));
            end
         end
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.c         = acc;

endmodule

// File: tb/tb_monty_mul_serial.sv
// Directed and streamed checks for monty_mul_serial; expected products are
// hand-computed constants or a bench-side 120-bit multiply.
module tb_monty_mul_serial;

   localparam int LOGQ = 60;
   localparam int LAT  = 3;
`ifdef MONTY_MUL_EARLY_DONE_EN
   localparam int LAT_B5  = 1;
   localparam int LAT_B0  = 1;
`else
   localparam int LAT_B5  = 3;
   localparam int LAT_B0  = 3;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   monty_mul_serial_if #(.LOGQ(LOGQ)) bus ();

   monty_mul_serial #(.LOGQ(LOGQ), .DW(20)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [2*LOGQ-1:0] exp_q[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Issues one operation from IDLE; returns edges from accept to out_valid (-1 on timeout).
   task automatic run_op(input logic [LOGQ-1:0] av, input logic [LOGQ-1:0] bv,
                         output int lat, output logic [2*LOGQ-1:0] cv);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = av;
      bus.b        = bv;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = -1;
      cv  = '0;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = k;
            cv  = bus.c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      #12;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready);
      end
      checks++;
      if (bus.c !== '0) begin
         errors++; $display("FAIL reset_c got %h want 0", bus.c);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_unit();
      int lat;
      logic [2*LOGQ-1:0] cv;
      bus.out_ready = 1'b1;
      run_op(60'd1, 60'd1, lat, cv);
      checks++;
      if (lat != LAT) begin
         errors++; $display("FAIL unit_latency got %0d want %0d", lat, LAT);
      end
      checks++;
      if (cv !== 120'h1) begin
         errors++; $display("FAIL unit_c got %h want 1", cv);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL unit_release got out_valid=%0b in_ready=%0b want 0/1",
                  bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_max();
      int lat;
      logic [2*LOGQ-1:0] cv;
      bus.out_ready = 1'b1;
      run_op(60'hFFFFFFFFFFFFFFF, 60'hFFFFFFFFFFFFFFF, lat, cv);
      checks++;
      if (cv !== 120'hFFFFFFFFFFFFFFE000000000000001) begin
         errors++; $display("FAIL max_c got %h want FFFFFFFFFFFFFFE000000000000001", cv);
      end
      checks++;
      if (lat != LAT) begin
         errors++; $display("FAIL max_latency got %0d want %0d", lat, LAT);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      logic [2*LOGQ-1:0] cv;
      bus.out_ready = 1'b0;
      run_op(60'd3, 60'd5, lat, cv);
      checks++;
      if (lat != LAT || cv !== 120'hF) begin
         errors++; $display("FAIL bp_first got lat=%0d c=%h want %0d/F", lat, cv, LAT);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.a        = 60'd100;
         bus.b        = 60'd100;
         @(posedge clk);
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.c !== 120'hF || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got out_valid=%0b c=%h in_ready=%0b want 1/F/0",
                     i, bus.out_valid, bus.c, bus.in_ready);
         end
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got out_valid=%0b in_ready=%0b want 0/1",
                  bus.out_valid, bus.in_ready);
      end
      bad = 0;
      for (int i = 0; i < LAT + 3; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL bp_no_capture got %0d busy cycles want 0", bad);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [2*LOGQ-1:0] cv;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 60'h123;
      bus.b        = 60'h456;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.c !== '0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid got out_valid=%0b c=%h in_ready=%0b want 0/0/1",
                  bus.out_valid, bus.c, bus.in_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      run_op(60'd7, 60'd9, lat, cv);
      checks++;
      if (cv !== 120'h3F || lat != LAT) begin
         errors++; $display("FAIL rst_after got c=%h lat=%0d want 3F/%0d", cv, lat, LAT);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_early_done();
      int lat;
      logic [2*LOGQ-1:0] cv;
      logic [2*LOGQ-1:0] want;
      bus.out_ready = 1'b1;
      run_op(60'hABC, 60'd5, lat, cv);
      checks++;
      if (cv !== 120'h35AC || lat != LAT_B5) begin
         errors++; $display("FAIL early_b5 got c=%h lat=%0d want 35AC/%0d", cv, lat, LAT_B5);
      end
      @(posedge clk);
      #1;
      run_op(60'hABC, 60'h1 << 45, lat, cv);
      want = 120'hABC << 45;
      checks++;
      if (cv !== want || lat != LAT) begin
         errors++; $display("FAIL early_b45 got c=%h lat=%0d want %h/%0d", cv, lat, want, LAT);
      end
      @(posedge clk);
      #1;
      run_op(60'hFFF, 60'd0, lat, cv);
      checks++;
      if (cv !== '0 || lat != LAT_B0) begin
         errors++; $display("FAIL early_b0 got c=%h lat=%0d want 0/%0d", cv, lat, LAT_B0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int got;
      fork
         begin : driver
            logic [63:0]      r;
            logic [LOGQ-1:0]  av, bv;
            int               wd;
            for (int i = 0; i < 100; i++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               r  = {$urandom(), $urandom()};
               av = r[LOGQ-1:0];
               r  = {$urandom(), $urandom()};
               bv = (i % 10 == 3) ? '0 : r[LOGQ-1:0];
               @(negedge clk);
               bus.in_valid = 1'b1;
               bus.a        = av;
               bus.b        = bv;
               exp_q.push_back({{LOGQ{1'b0}}, av} * {{LOGQ{1'b0}}, bv});
               wd = 0;
               while (!bus.in_ready && wd < 200) begin
                  @(negedge clk);
                  wd++;
               end
               if (wd >= 200) begin
                  errors++; $display("FAIL b2b_accept_timeout op %0d", i);
                  bus.in_valid = 1'b0;
                  break;
               end
               @(posedge clk);
               #1;
               bus.in_valid = 1'b0;
            end
         end
         begin : monitor
            logic [2*LOGQ-1:0] e;
            int budget;
            got    = 0;
            budget = 0;
            while (got < 100 && budget < 20000) begin
               @(negedge clk);
               budget++;
               bus.out_ready = ($urandom_range(0, 3) != 0);
               if (bus.out_valid && bus.out_ready) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++; $display("FAIL b2b_extra got c=%h with nothing issued", bus.c);
                  end else begin
                     e = exp_q.pop_front();
                     if (bus.c !== e) begin
                        errors++; $display("FAIL b2b_c item %0d got %h want %h", got, bus.c, e);
                     end
                  end
                  got++;
               end
            end
            if (got < 100) begin
               errors++; $display("FAIL b2b_timeout got %0d products want 100", got);
            end
         end
      join
      bus.out_ready = 1'b1;
      repeat (LAT + 3) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain got out_valid=%0b pending=%0d want 0/0",
                  bus.out_valid, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_unit();
      test_max();
      test_backpressure();
      test_reset_mid();
      test_early_done();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
